pipeline_hazard_controller: RTL and testbench

Sequences the five-stage pipelined version of the processor datapath: it detects load-use and branch-operand hazards, squashes wrong-path fetches after taken bne/j, and freezes the front of the pipe while a multi-cycle mul occupies EX. It sits beside the main instruction decoder, consumes decoded ID-stage fields plus EX/MEM destination information, and drives the pipeline-register write/bubble controls. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/mul_sequencer.sv | 55 +++++
 rtl/pipeline_hazard_controller.sv | 109 ++++++++++
 tb/tb_pipeline_hazard_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipeline
// hazard controller slice.
package pipeline_pkg;

  typedef enum logic {
    HZ_IDLE,
    HZ_MUL_BUSY
  } hz_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_MUL   = 6'b011100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mul_sequencer.sv
// Tracks a multi-cycle mul occupying EX: IDLE/BUSY FSM
// with a countdown of remaining frozen cycles.
module mul_sequencer
  import pipeline_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic MulBusy
);

  localparam logic [3:0] LOAD = 4'(MUL_LATENCY - 1);

  hz_state_e  state, state_nx;
  logic [3:0] count, count_nx;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= HZ_IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    unique case (state)
      HZ_IDLE: begin
        if (start && MUL_LATENCY > 1) begin
          state_nx = HZ_MUL_BUSY;
          count_nx = LOAD;
        end
      end
      HZ_MUL_BUSY: begin
        count_nx = count - 4'd1;
        if (count == 4'd1) begin
          state_nx = HZ_IDLE;
        end
      end
      default: begin
        state_nx = HZ_IDLE;
        count_nx = '0;
      end
    endcase
  end

  // Reset must read as not-busy in the same cycle it is raised.
  assign MulBusy = (state == HZ_MUL_BUSY) && !Reset;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use / branch-operand hazard detection, redirect squash
// and mul freeze control for the five-stage pipeline.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_IsMul,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_Jump,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WriteReg,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Write,
  output logic        IDEX_Bubble,
  output logic        EXMEM_Bubble,
  output logic        MulBusy,
  output logic [31:0] StallCycles
);

  logic ex_nz, mem_nz;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, branch_haz, stall;
  logic redirect, mul_start;

  assign ex_nz  = EX_WriteReg != REG_ZERO;
  assign mem_nz = MEM_WriteReg != REG_ZERO;

  assign rs_ex  = ex_nz && (ID_Rs == EX_WriteReg);
  assign rt_ex  = ex_nz && (ID_Rt == EX_WriteReg);
  assign rs_mem = mem_nz && (ID_Rs == MEM_WriteReg);
  assign rt_mem = mem_nz && (ID_Rt == MEM_WriteReg);

  assign load_use = EX_MemRead &&
    ((ID_UsesRs && rs_ex) || (ID_UsesRt && rt_ex));

  // bne compares in ID, so both operands matter whatever the flags say.
  assign branch_haz = ID_Branch &&
    ((EX_RegWrite && (rs_ex || rt_ex)) ||
     (MEM_MemRead && (rs_mem || rt_mem)));

  assign stall     = load_use || branch_haz;
  assign redirect  = ID_Jump || (ID_Branch && ID_BranchTaken);
  assign mul_start = ID_IsMul && !stall;

  mul_sequencer #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_mul_seq (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (mul_start),
    .MulBusy(MulBusy)
  );

  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    priority case (1'b1)
      Reset: begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IFID_Flush   = 1'b1;
        IDEX_Write   = 1'b0;
        IDEX_Bubble  = 1'b1;
        EXMEM_Bubble = 1'b1;
      end
      MulBusy: begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
      end
      stall: begin
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end
      redirect: begin
        IFID_Flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCycles <= '0;
    end else if (!PCWrite && StallCycles != 32'hFFFF_FFFF) begin
      StallCycles <= StallCycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed vector table plus multi-cycle sequences for the
// pipeline hazard controller.
module tb_pipeline_hazard_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt;
  logic        ID_UsesRs, ID_UsesRt;
  logic        ID_IsMul, ID_Branch;
  logic        ID_BranchTaken, ID_Jump;
  logic        EX_RegWrite, EX_MemRead;
  logic [4:0]  EX_WriteReg;
  logic        MEM_MemRead;
  logic [4:0]  MEM_WriteReg;
  logic        PCWrite, IFID_Write, IFID_Flush;
  logic        IDEX_Write, IDEX_Bubble, EXMEM_Bubble;
  logic        MulBusy;
  logic [31:0] StallCycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_controller #(.MUL_LATENCY(3)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ID_Rs         (ID_Rs),
    .ID_Rt         (ID_Rt),
    .ID_UsesRs     (ID_UsesRs),
    .ID_UsesRt     (ID_UsesRt),
    .ID_IsMul      (ID_IsMul),
    .ID_Branch     (ID_Branch),
    .ID_BranchTaken(ID_BranchTaken),
    .ID_Jump       (ID_Jump),
    .EX_RegWrite   (EX_RegWrite),
    .EX_MemRead    (EX_MemRead),
    .EX_WriteReg   (EX_WriteReg),
    .MEM_MemRead   (MEM_MemRead),
    .MEM_WriteReg  (MEM_WriteReg),
    .PCWrite       (PCWrite),
    .IFID_Write    (IFID_Write),
    .IFID_Flush    (IFID_Flush),
    .IDEX_Write    (IDEX_Write),
    .IDEX_Bubble   (IDEX_Bubble),
    .EXMEM_Bubble  (EXMEM_Bubble),
    .MulBusy       (MulBusy),
    .StallCycles   (StallCycles)
  );

  // {PCWrite,IFID_Write,IFID_Flush,IDEX_Write,IDEX_Bubble,EXMEM_Bubble}
  localparam logic [5:0] O_NORM  = 6'b110100;
  localparam logic [5:0] O_STALL = 6'b000110;
  localparam logic [5:0] O_REDIR = 6'b111100;
  localparam logic [5:0] O_BUSY  = 6'b000001;
  localparam logic [5:0] O_RST   = 6'b001011;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       urs, urt, br, tk, jmp;
    logic       exrw, exmr;
    logic [4:0] exwr;
    logic       memmr;
    logic [4:0] memwr;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic logic [5:0] outs();
    return {PCWrite, IFID_Write, IFID_Flush,
            IDEX_Write, IDEX_Bubble, EXMEM_Bubble};
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
    ID_IsMul = 0; ID_Branch = 0; ID_BranchTaken = 0;
    ID_Jump = 0; EX_RegWrite = 0; EX_MemRead = 0;
    EX_WriteReg = 0; MEM_MemRead = 0; MEM_WriteReg = 0;
  endtask

  task automatic apply(input vec_t v);
    ID_Rs = v.rs; ID_Rt = v.rt;
    ID_UsesRs = v.urs; ID_UsesRt = v.urt;
    ID_IsMul = 0; ID_Branch = v.br;
    ID_BranchTaken = v.tk; ID_Jump = v.jmp;
    EX_RegWrite = v.exrw; EX_MemRead = v.exmr;
    EX_WriteReg = v.exwr;
    MEM_MemRead = v.memmr; MEM_WriteReg = v.memwr;
  endtask

  task automatic nxt();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    nxt();
    idle_inputs();
    Reset = 1'b1;
    #1;
    check("rst_outs", 32'(outs()), 32'(O_RST));
    check("rst_mulbusy", 32'(MulBusy), 0);
    nxt();
    Reset = 1'b0;
    #1;
    check("rst_stallcnt", StallCycles, 0);
    check("rst_idle_outs", 32'(outs()), 32'(O_NORM));
  endtask

  initial begin
    //         name     rs rt urs urt br tk j exrw exmr exwr mmr mwr exp
    vt.push_back('{"zero",      0, 0, 0,0,0,0,0, 0,0, 0, 0, 0, O_NORM});
    vt.push_back('{"lu_rs",     8, 3, 1,1,0,0,0, 1,1, 8, 0, 0, O_STALL});
    vt.push_back('{"lu_r0",     0, 3, 1,1,0,0,0, 1,1, 0, 0, 0, O_NORM});
    vt.push_back('{"lu_rt",     4, 8, 0,1,0,0,0, 1,1, 8, 0, 0, O_STALL});
    vt.push_back('{"lu_rt_nu",  4, 8, 1,0,0,0,0, 1,1, 8, 0, 0, O_NORM});
    vt.push_back('{"lu_miss",   7, 6, 1,1,0,0,0, 1,1, 8, 0, 0, O_NORM});
    vt.push_back('{"alu_nobr",  8, 8, 1,1,0,0,0, 1,0, 8, 0, 0, O_NORM});
    vt.push_back('{"bh_ex",     9, 2, 1,1,1,0,0, 1,0, 9, 0, 0, O_STALL});
    vt.push_back('{"bh_mem",    2, 9, 1,1,1,1,0, 0,0, 0, 1, 9, O_STALL});
    vt.push_back('{"bh_nouse",  9, 2, 0,0,1,0,0, 1,0, 9, 0, 0, O_STALL});
    vt.push_back('{"bh_nowr",   9, 2, 1,1,1,0,0, 0,0, 9, 0, 9, O_NORM});
    vt.push_back('{"bh_r0",     0, 0, 1,1,1,1,0, 1,0, 0, 1, 0, O_REDIR});
    vt.push_back('{"bne_taken", 5, 6, 1,1,1,1,0, 1,0, 7, 1, 3, O_REDIR});
    vt.push_back('{"bne_nt",    5, 6, 1,1,1,0,0, 1,0, 7, 1, 3, O_NORM});
    vt.push_back('{"jump",      0, 0, 0,0,0,0,1, 0,0, 0, 0, 0, O_REDIR});
    vt.push_back('{"jump_lu",   8, 0, 1,0,0,0,1, 1,1, 8, 0, 0, O_STALL});

    idle_inputs();
    Reset = 1'b1;
    nxt();
    nxt();
    #1;
    check("init_rst_outs", 32'(outs()), 32'(O_RST));
    Reset = 1'b0;
    nxt();
    #1;
    check("init_cnt", StallCycles, 0);

    foreach (vt[i]) begin
      nxt();
      apply(vt[i]);
      #1;
      check(vt[i].name, 32'(outs()), 32'(vt[i].exp));
      check({vt[i].name, "_mb"}, 32'(MulBusy), 0);
    end

    do_reset();

    // load-use: one stall cycle, counter 0 -> 1
    nxt();
    ID_Rs = 8; ID_UsesRs = 1; EX_MemRead = 1;
    EX_RegWrite = 1; EX_WriteReg = 8;
    #1;
    check("lu_stall", 32'(outs()), 32'(O_STALL));
    check("lu_cnt0", StallCycles, 0);
    nxt();
    idle_inputs();
    ID_Rs = 8; ID_UsesRs = 1;
    MEM_WriteReg = 8;
    #1;
    check("lu_release", 32'(outs()), 32'(O_NORM));
    check("lu_cnt1", StallCycles, 1);

    // bne behind an lw: EX stall, MEM stall, then taken
    nxt();
    idle_inputs();
    ID_Branch = 1; ID_Rs = 9; ID_Rt = 2;
    EX_RegWrite = 1; EX_MemRead = 1; EX_WriteReg = 9;
    #1;
    check("br_c1", 32'(outs()), 32'(O_STALL));
    nxt();
    EX_RegWrite = 0; EX_MemRead = 0; EX_WriteReg = 0;
    MEM_MemRead = 1; MEM_WriteReg = 9;
    #1;
    check("br_c2", 32'(outs()), 32'(O_STALL));
    nxt();
    MEM_MemRead = 0; MEM_WriteReg = 0;
    ID_BranchTaken = 1;
    #1;
    check("br_c3", 32'(outs()), 32'(O_REDIR));
    check("br_cnt", StallCycles, 3);

    // mul: 2 frozen cycles, jump held during BUSY
    nxt();
    idle_inputs();
    ID_IsMul = 1;
    #1;
    check("mul_issue", 32'(outs()), 32'(O_NORM));
    check("mul_issue_mb", 32'(MulBusy), 0);
    nxt();
    idle_inputs();
    ID_Jump = 1;
    #1;
    check("mul_b1", 32'(outs()), 32'(O_BUSY));
    check("mul_b1_mb", 32'(MulBusy), 1);
    nxt();
    #1;
    check("mul_b2", 32'(outs()), 32'(O_BUSY));
    check("mul_b2_mb", 32'(MulBusy), 1);
    nxt();
    #1;
    check("mul_rel_mb", 32'(MulBusy), 0);
    check("mul_rel_jump", 32'(outs()), 32'(O_REDIR));
    check("mul_cnt", StallCycles, 5);

    // jump coincident with load-use
    nxt();
    idle_inputs();
    ID_Jump = 1; ID_Rt = 8; ID_UsesRt = 1;
    EX_MemRead = 1; EX_WriteReg = 8;
    #1;
    check("jlu_c1", 32'(outs()), 32'(O_STALL));
    nxt();
    EX_MemRead = 0; EX_WriteReg = 0;
    #1;
    check("jlu_c2", 32'(outs()), 32'(O_REDIR));
    check("jlu_cnt", StallCycles, 6);

    // mul held by a load-use stall does not start
    nxt();
    idle_inputs();
    ID_IsMul = 1; ID_Rs = 8; ID_UsesRs = 1;
    EX_MemRead = 1; EX_WriteReg = 8;
    #1;
    check("mullu_stall", 32'(outs()), 32'(O_STALL));
    nxt();
    idle_inputs();
    #1;
    check("mullu_mb", 32'(MulBusy), 0);
    check("mullu_outs", 32'(outs()), 32'(O_NORM));
    check("mullu_cnt", StallCycles, 7);

    // reset in the second BUSY cycle
    nxt();
    ID_IsMul = 1;
    nxt();
    idle_inputs();
    #1;
    check("rb_b1_mb", 32'(MulBusy), 1);
    nxt();
    Reset = 1'b1;
    #1;
    check("rb_rst_outs", 32'(outs()), 32'(O_RST));
    check("rb_rst_mb", 32'(MulBusy), 0);
    nxt();
    Reset = 1'b0;
    #1;
    check("rb_after_mb", 32'(MulBusy), 0);
    check("rb_after_cnt", StallCycles, 0);
    check("rb_after_outs", 32'(outs()), 32'(O_NORM));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
